trng_health_ctrl: RTL and testbench
===================================

Name: trng_health_ctrl

Overview:
- Sits directly downstream of the TRNG word collector; sits between the collector and all crypto consumers (key gen, nonce gen).
- Drives the collector's request line and captures each 32-bit word when the collector reports ready.
- Runs online health tests on every raw word: a repetition-count test (RCT) and an adaptive-proportion test (APT) over a window.
- Hands only words that pass to the consumer over a valid/ack handshake; a failing test halts the block until software clears it.

Parameters:
- RCT_LIMIT, 3: number of consecutive identical words that declares a failure (range 2..15).
- APT_WINDOW, 16: window length in words; must be a power of two, range 2..64.
- APT_LO, 192: minimum total ones per window (of APT_WINDOW*32 bits).
- APT_HI, 320: maximum total ones per window.
- STARTUP_DISCARD, 4: words captured and discarded after reset or clear before output is allowed (range 0..15).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- enable, input, 1: block enable; low stops new fetches.
- trng_request, output, 1: request to the collector.
- trng_data, input, 32: collector random_number.
- trng_ready, input, 1: collector ready.
- out_data, output, 32: validated random word.
- out_valid, output, 1: out_data is valid; held until accepted.
- out_ack, input, 1: consumer accepts out_data.
- health_fail, output, 1: sticky failure flag.
- fail_cause, output, 2: bit0 = RCT, bit1 = APT; sticky with health_fail.
- fail_clear, input, 1: single-cycle pulse; honoured only in FAIL.
- startup_done, output, 1: high once STARTUP_DISCARD words have been consumed.

Behaviour:
- Reset:
  - All outputs 0.
  - FSM in IDLE.
  - Counters and the previous-word register are 0.
  - The RCT "previous valid" flag is 0, so the first word never counts as a repeat.
- FSM states and transitions:
  - IDLE: trng_request=0. Go to REQ when enable=1.
  - REQ: trng_request=1.
    - On trng_ready=1: capture trng_data into raw_word and go to DROP.
    - If enable=0 before trng_ready: go to IDLE with no capture.
  - DROP: trng_request=0. Wait until trng_ready=0, then go to CHECK. Minimum 1 cycle; this guarantees the collector restarts a fresh 32-bit accumulation.
  - CHECK: exactly 1 cycle. Update the health tests using raw_word.
    - Any failure: health_fail=1, fail_cause bits set, go to FAIL. The word is discarded.
    - Pass while the startup counter < STARTUP_DISCARD: increment the counter and go to REQ (or IDLE if enable=0). At the terminal count, startup_done=1.
    - Pass with startup_done=1: load out_data, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1 and out_data stable.
    - On out_ack=1: out_valid=0 in the next cycle; go to REQ (or IDLE if enable=0).
    - enable=0 does not withdraw a valid word.
  - FAIL: trng_request=0 and out_valid=0. On fail_clear=1:
    - clear health_fail and fail_cause;
    - clear the RCT count, APT accumulator, window counter and startup counter;
    - set startup_done=0 and the previous-valid flag to 0;
    - go to IDLE.
- Latency: capture -> out_valid is DROP (≥1 cycle) + CHECK (1 cycle); minimum 2 cycles after the trng_ready capture edge.
- RCT:
  - If raw_word == prev_word and previous-valid is set: rct_cnt++. Otherwise rct_cnt=1.
  - Fail when rct_cnt reaches RCT_LIMIT.
  - prev_word is updated every CHECK.
- APT:
  - Accumulator of popcount(raw_word) sums into 12 bits.
  - On the APT_WINDOW-th word, compare the sum including the current word against [APT_LO, APT_HI], inclusive bounds.
  - Out of range = fail. Then clear the accumulator and window counter; the counter wraps.
- RCT and APT are evaluated in the same CHECK. Both failing sets both fail_cause bits.
- Health tests also run on startup-discard words, and failures there are reported.
- fail_clear outside FAIL is ignored.
- Async reset mid-operation (any state, including HOLD with out_valid=1) returns to the reset values immediately; the pending word is lost.

Optional Feature:
- Macro TRNG_WHITEN_EN.
- Defined: out_data = raw_word XOR prev_word, where prev_word is the value before this CHECK's update. The first word after reset or clear is XORed with 0. Health tests always use raw_word.
- Undefined: out_data = raw_word. No extra logic.

Decomposition:
- Shared package trng_pkg:
  - TRNG_WORD_W=32;
  - FSM state encoding (IDLE, REQ, DROP, CHECK, HOLD, FAIL);
  - fail_cause bit indices;
  - default RCT/APT/STARTUP constants.
- One sub-module, trng_health_test:
  - contains the RCT counter, previous-word register, popcount, APT accumulator and window counter;
  - inputs: clk, rst_n, raw_word, check strobe, clear;
  - outputs: rct_fail, apt_fail, prev_word.
- The top module keeps the FSM, startup counter and handshake.

Test Plan:
1. Startup: collector model returns distinct words with 16 ones each, STARTUP_DISCARD=4 -> words 1–4 never appear. startup_done rises in the CHECK of word 4. Word 5 appears on out_data with out_valid=1.
2. Handshake: hold out_ack=0 for 10 cycles -> out_valid stays 1 and out_data stays stable, trng_request=0. Pulse out_ack -> out_valid=0 in the next cycle, trng_request=1 in the following cycle.
3. RCT: feed 0xA5A5A5A5 three times consecutively -> after the third CHECK, health_fail=1, fail_cause=2'b01, no output, trng_request stays 0.
4. APT: feed 16 words of 0xFFFFFFFF with distinct... not possible. Instead use rotating values with 28 ones each (sum 448 > 320) -> at word 16, fail_cause=2'b10. Then pulse fail_clear -> back to IDLE, startup_done=0, discard restarts.
5. enable and reset edges: drop enable in REQ -> IDLE, no capture. Assert rst_n=0 in HOLD -> out_valid=0, out_data=0 asynchronously, with no clock edge required.
6. With TRNG_WHITEN_EN: consecutive words 0x0000FFFF then 0x00FF00FF -> second output = 0x00FFFF00.

Source files
------------

// File: rtl/trng_health_ctrl_pkg.sv
// Shared definitions for the TRNG health controller: word width, FSM encoding,
// fail_cause bit positions, default health-test limits and a popcount helper.
package trng_pkg;

    localparam int TRNG_WORD_W = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_DROP  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_FAIL  = 3'd5;

    localparam int FAIL_RCT_BIT = 0;
    localparam int FAIL_APT_BIT = 1;

    localparam int DEF_RCT_LIMIT       = 3;
    localparam int DEF_APT_WINDOW      = 16;
    localparam int DEF_APT_LO          = 192;
    localparam int DEF_APT_HI          = 320;
    localparam int DEF_STARTUP_DISCARD = 4;

    function automatic logic [5:0] popcount(input logic [TRNG_WORD_W-1:0] w);
        logic [5:0] c;
        c = '0;
        for (int unsigned i = 0; i < TRNG_WORD_W; i++) begin
            c = c + 6'(w[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/trng_health_test.sv
// Online health tests: repetition-count test and adaptive-proportion test.
// Fail outputs are combinational and valid only in the cycle check is high.
module trng_health_test
    import trng_pkg::*;
#(
    parameter int RCT_LIMIT  = DEF_RCT_LIMIT,
    parameter int APT_WINDOW = DEF_APT_WINDOW,
    parameter int APT_LO     = DEF_APT_LO,
    parameter int APT_HI     = DEF_APT_HI
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TRNG_WORD_W-1:0] raw_word,
    input  logic                   check,
    input  logic                   clear,
    output logic                   rct_fail,
    output logic                   apt_fail,
    output logic [TRNG_WORD_W-1:0] prev_word
);

    localparam int WIN_W = $clog2(APT_WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(APT_WINDOW - 1);
    localparam logic [3:0]  RCT_LIM = 4'(RCT_LIMIT);
    localparam logic [11:0] APT_LO_W = 12'(APT_LO);
    localparam logic [11:0] APT_HI_W = 12'(APT_HI);

    logic [TRNG_WORD_W-1:0] prev_q, prev_d;
    logic                   prev_valid_q, prev_valid_d;
    logic [3:0]             rct_cnt_q, rct_cnt_d;
    logic [11:0]            apt_acc_q, apt_acc_d;
    logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;

    logic [3:0]  rct_next;
    logic [11:0] apt_sum;
    logic        win_last;

    always_comb begin
        rct_next = (prev_valid_q && (raw_word == prev_q)) ? rct_cnt_q + 4'd1 : 4'd1;
        apt_sum  = apt_acc_q + 12'(popcount(raw_word));
        win_last = (win_cnt_q == WIN_LAST);

        rct_fail = check && (rct_next >= RCT_LIM);
        apt_fail = check && win_last && ((apt_sum < APT_LO_W) || (apt_sum > APT_HI_W));

        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        rct_cnt_d    = rct_cnt_q;
        apt_acc_d    = apt_acc_q;
        win_cnt_d    = win_cnt_q;

        if (clear) begin
            prev_d       = '0;
            prev_valid_d = 1'b0;
            rct_cnt_d    = '0;
            apt_acc_d    = '0;
            win_cnt_d    = '0;
        end else if (check) begin
            prev_d       = raw_word;
            prev_valid_d = 1'b1;
            rct_cnt_d    = rct_next;
            // power-of-two window: the counter wraps to 0 on its own
            win_cnt_d    = win_cnt_q + 1'b1;
            apt_acc_d    = win_last ? '0 : apt_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            rct_cnt_q    <= '0;
            apt_acc_q    <= '0;
            win_cnt_q    <= '0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            rct_cnt_q    <= rct_cnt_d;
            apt_acc_q    <= apt_acc_d;
            win_cnt_q    <= win_cnt_d;
        end
    end

    assign prev_word = prev_q;

endmodule

// File: rtl/trng_health_ctrl.sv
// TRNG health controller: fetches words from the collector, health-tests them
// and forwards passing words over valid/ack. Optional TRNG_WHITEN_EN XORs out_data with the previous word.
module trng_health_ctrl
    import trng_pkg::*;
#(
    parameter int RCT_LIMIT       = DEF_RCT_LIMIT,
    parameter int APT_WINDOW      = DEF_APT_WINDOW,
    parameter int APT_LO          = DEF_APT_LO,
    parameter int APT_HI          = DEF_APT_HI,
    parameter int STARTUP_DISCARD = DEF_STARTUP_DISCARD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    output logic                   trng_request,
    input  logic [TRNG_WORD_W-1:0] trng_data,
    input  logic                   trng_ready,
    output logic [TRNG_WORD_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ack,
    output logic                   health_fail,
    output logic [1:0]             fail_cause,
    input  logic                   fail_clear,
    output logic                   startup_done
);

`ifdef TRNG_WHITEN_EN
    localparam logic WHITEN = 1'b1;
`else
    localparam logic WHITEN = 1'b0;
`endif
    localparam logic [3:0] DISCARD = 4'(STARTUP_DISCARD);

    logic [2:0]             state_q, state_d;
    logic [TRNG_WORD_W-1:0] raw_word_q, raw_word_d;
    logic [TRNG_WORD_W-1:0] out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic [3:0]             startup_cnt_q, startup_cnt_d;
    logic                   startup_done_q, startup_done_d;
    logic                   health_fail_q, health_fail_d;
    logic [1:0]             fail_cause_q, fail_cause_d;

    logic                   check, clear, rct_fail, apt_fail;
    logic [TRNG_WORD_W-1:0] prev_word, out_word;

    assign check = (state_q == ST_CHECK);
    assign clear = (state_q == ST_FAIL) && fail_clear;
    // WHITEN is constant, so the XOR folds away entirely when the feature is off
    assign out_word = raw_word_q ^ (prev_word & {TRNG_WORD_W{WHITEN}});

    trng_health_test #(
        .RCT_LIMIT  (RCT_LIMIT),
        .APT_WINDOW (APT_WINDOW),
        .APT_LO     (APT_LO),
        .APT_HI     (APT_HI)
    ) u_health (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_word  (raw_word_q),
        .check     (check),
        .clear     (clear),
        .rct_fail  (rct_fail),
        .apt_fail  (apt_fail),
        .prev_word (prev_word)
    );

    always_comb begin
        state_d        = state_q;
        raw_word_d     = raw_word_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        startup_cnt_d  = startup_cnt_q;
        startup_done_d = startup_done_q;
        health_fail_d  = health_fail_q;
        fail_cause_d   = fail_cause_q;

        case (state_q)
            ST_IDLE: if (enable) state_d = ST_REQ;
            ST_REQ: begin
                if (trng_ready) begin
                    raw_word_d = trng_data;
                    state_d    = ST_DROP;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: if (!trng_ready) state_d = ST_CHECK;
            ST_CHECK: begin
                if (rct_fail || apt_fail) begin
                    health_fail_d                = 1'b1;
                    fail_cause_d[FAIL_RCT_BIT]   = rct_fail;
                    fail_cause_d[FAIL_APT_BIT]   = apt_fail;
                    state_d                      = ST_FAIL;
                end else if (startup_cnt_q < DISCARD) begin
                    startup_cnt_d  = startup_cnt_q + 4'd1;
                    startup_done_d = (startup_cnt_q + 4'd1 == DISCARD);
                    state_d        = enable ? ST_REQ : ST_IDLE;
                end else begin
                    out_data_d     = out_word;
                    out_valid_d    = 1'b1;
                    startup_done_d = 1'b1;
                    state_d        = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ack) begin
                    out_valid_d = 1'b0;
                    state_d     = enable ? ST_REQ : ST_IDLE;
                end
            end
            ST_FAIL: begin
                if (fail_clear) begin
                    health_fail_d  = 1'b0;
                    fail_cause_d   = '0;
                    startup_cnt_d  = '0;
                    startup_done_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            raw_word_q     <= '0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            startup_cnt_q  <= '0;
            startup_done_q <= 1'b0;
            health_fail_q  <= 1'b0;
            fail_cause_q   <= '0;
        end else begin
            state_q        <= state_d;
            raw_word_q     <= raw_word_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            startup_cnt_q  <= startup_cnt_d;
            startup_done_q <= startup_done_d;
            health_fail_q  <= health_fail_d;
            fail_cause_q   <= fail_cause_d;
        end
    end

    assign trng_request = (state_q == ST_REQ);
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign health_fail  = health_fail_q;
    assign fail_cause   = fail_cause_q;
    assign startup_done = startup_done_q;

endmodule

// File: tb/tb_trng_health_ctrl.sv
// Directed bench for trng_health_ctrl with a transaction-level reference model
// and a per-cycle output compare process.
module tb_trng_health_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        trng_request;
    logic [31:0] trng_data;
    logic        trng_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ack;
    logic        health_fail;
    logic [1:0]  fail_cause;
    logic        fail_clear;
    logic        startup_done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] feed_q[$];
    logic [31:0] exp_q[$];
    bit          auto_ack = 1'b0;

    logic [31:0] m_prev;
    bit          m_pv;
    int          m_rct, m_sum, m_win, m_start;
    logic [1:0]  m_cause;

    always #5 clk = ~clk;

    trng_health_ctrl #(
        .RCT_LIMIT       (3),
        .APT_WINDOW      (16),
        .APT_LO          (192),
        .APT_HI          (320),
        .STARTUP_DISCARD (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .trng_request (trng_request),
        .trng_data    (trng_data),
        .trng_ready   (trng_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ack      (out_ack),
        .health_fail  (health_fail),
        .fail_cause   (fail_cause),
        .fail_clear   (fail_clear),
        .startup_done (startup_done)
    );

    function automatic logic [31:0] rotl(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    task automatic model_reset();
        m_prev = '0; m_pv = 0; m_rct = 0; m_sum = 0; m_win = 0; m_start = 0; m_cause = '0;
    endtask

    // Whole-word view of the rules: repeat run length, ones per window, discard count.
    task automatic model_word(input logic [31:0] w);
        bit rf, af;
        logic [31:0] o;
        if (m_pv && w == m_prev) m_rct++; else m_rct = 1;
        rf = (m_rct >= 3);
        m_sum += $countones(w);
        m_win++;
        af = 0;
        if (m_win == 16) begin
            af = (m_sum < 192) || (m_sum > 320);
            m_win = 0;
            m_sum = 0;
        end
`ifdef TRNG_WHITEN_EN
        o = w ^ m_prev;
`else
        o = w;
`endif
        m_prev = w;
        m_pv = 1;
        if (rf || af) m_cause = {af, rf};
        else if (m_start < 4) m_start++;
        else exp_q.push_back(o);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_for(input int sel, input int limit, input string name);
        bit ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            case (sel)
                0: ok = out_valid;
                1: ok = health_fail;
                default: ok = startup_done;
            endcase
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=timeout required=event", name);
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1 out_ack = 1'b1;
        @(posedge clk); #1 out_ack = 1'b0;
    endtask

    task automatic clear_pulse();
        @(posedge clk); #1 fail_clear = 1'b1;
        @(posedge clk); #1 fail_clear = 1'b0;
    endtask

    // Collector model: one-cycle ready pulse per requested word.
    initial begin
        trng_ready = 1'b0;
        trng_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) trng_ready = 1'b0;
            else if (trng_ready) trng_ready = 1'b0;
            else if (trng_request && feed_q.size() > 0) begin
                trng_data  = feed_q.pop_front();
                trng_ready = 1'b1;
                model_word(trng_data);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (auto_ack) out_ack = out_valid;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=%h required=none", out_data);
                end else begin
                    chk("out_data", out_data, exp_q[0]);
                    chk("valid_vs_fail", {31'b0, health_fail}, 32'd0);
                    if (out_ack) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] w5_exp, w6_exp;
`ifdef TRNG_WHITEN_EN
        w5_exp = 32'h0008_0008;
        w6_exp = 32'h00FF_FF00;
`else
        w5_exp = 32'h000F_FFF0;
        w6_exp = 32'h00FF_00FF;
`endif
        model_reset();
        rst_n = 1'b0; enable = 1'b0; out_ack = 1'b0; fail_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_request", {31'b0, trng_request}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_fail", {29'b0, health_fail, fail_cause}, 32'd0);
        chk("rst_startup", {31'b0, startup_done}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; enable = 1'b1;

        // Startup discard then first output
        for (int i = 0; i < 5; i++) feed_q.push_back(rotl(32'h0000_FFFF, i));
        wait_for(2, 200, "startup_wait");
        chk("startup_no_valid", {31'b0, out_valid}, 32'd0);
        wait_for(0, 100, "w5_wait");
        chk("w5_literal", out_data, w5_exp);

        // Hold without ack; fail_clear ignored outside FAIL
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_data", out_data, w5_exp);
            chk("hold_request", {31'b0, trng_request}, 32'd0);
            if (i == 3) begin
                fail_clear = 1'b1;
                @(negedge clk);
                fail_clear = 1'b0;
            end
        end
        chk("clear_ignored", {30'b0, health_fail, startup_done}, 32'd1);
        ack_pulse();
        chk("ack_valid_low", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk("ack_request", {31'b0, trng_request}, 32'd1);

        // RCT failure
        auto_ack = 1'b1;
        repeat (3) feed_q.push_back(32'hA5A5_A5A5);
        wait_for(1, 200, "rct_wait");
        chk("rct_cause", {30'b0, fail_cause}, 32'd1);
        chk("rct_cause_model", {30'b0, fail_cause}, {30'b0, m_cause});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fail_request", {31'b0, trng_request}, 32'd0);
            chk("fail_valid", {31'b0, out_valid}, 32'd0);
        end
        clear_pulse();
        model_reset();
        chk("rct_cleared", {29'b0, health_fail, fail_cause}, 32'd0);
        chk("rct_startup_cleared", {31'b0, startup_done}, 32'd0);

        // APT failure: 16 words of 28 ones
        for (int i = 0; i < 16; i++) feed_q.push_back(rotl(32'hFFFF_FFF0, i));
        wait_for(1, 600, "apt_wait");
        chk("apt_cause", {30'b0, fail_cause}, 32'd2);
        chk("apt_cause_model", {30'b0, fail_cause}, {30'b0, m_cause});
        auto_ack = 1'b0;
        clear_pulse();
        model_reset();
        chk("apt_cleared", {29'b0, health_fail, fail_cause}, 32'd0);
        chk("apt_startup_cleared", {31'b0, startup_done}, 32'd0);
        for (int i = 0; i < 4; i++) feed_q.push_back(rotl(32'h0000_FFFF, 16 + i));
        wait_for(2, 200, "restart_wait");
        chk("restart_no_valid", {31'b0, out_valid}, 32'd0);
        feed_q.push_back(rotl(32'h0000_FFFF, 24));
        wait_for(0, 100, "restart_out_wait");
        ack_pulse();

        // enable drop in REQ
        @(posedge clk); #1;
        chk("req_before_drop", {31'b0, trng_request}, 32'd1);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_drop", {31'b0, trng_request}, 32'd0);
        feed_q.push_back(rotl(32'h0000_FFFF, 28));
        repeat (3) @(posedge clk);
        #1;
        chk("no_capture", feed_q.size(), 32'd1);
        chk("idle_request", {31'b0, trng_request}, 32'd0);
        enable = 1'b1;
        wait_for(0, 100, "reenable_wait");

        // Async reset while holding a word
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, out_valid}, 32'd0);
        chk("async_data", out_data, 32'd0);
        chk("async_startup", {31'b0, startup_done}, 32'd0);
        exp_q.delete();
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;

        // Whitening pair (plain pass-through when the feature is off)
        for (int i = 0; i < 4; i++) feed_q.push_back(rotl(32'h0000_FFFF, 8 + i));
        feed_q.push_back(32'h0000_FFFF);
        feed_q.push_back(32'h00FF_00FF);
        wait_for(2, 200, "w6_startup_wait");
        wait_for(0, 100, "w6a_wait");
        ack_pulse();
        wait_for(0, 100, "w6b_wait");
        chk("w6_literal", out_data, w6_exp);
        ack_pulse();
        repeat (3) @(posedge clk);
        chk("exp_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
